// File: rtl/egress_cpld_gen.sv
// egress_cpld_gen: answers one 1-DW MRd with a 3DW-header CplD on a 64-bit AXIS TX stream.
// Optional macro CPL_UR_EN: requests with length != 1 get a UR Cpl without data instead.
module egress_cpld_gen #(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_RD_LAT     = 1
) (
    input  logic                      clk,
    input  logic                      rst_nm,
    input  logic [15:0]               cfg_completer_id,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [7:0]                req_tag,
    input  logic [15:0]               req_rid,
    input  logic [2:0]                req_tc,
    input  logic [1:0]                req_attr,
    input  logic [9:0]                req_len,
    input  logic [9:0]                req_addr,
    output logic                      rd_en,
    output logic [7:0]                rd_addr,
    input  logic [31:0]               rd_data,
    input  logic                      m_axis_tx_tready,
    output logic [C_DATA_WIDTH-1:0]   m_axis_tx_tdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axis_tx_tkeep,
    output logic                      m_axis_tx_sop,
    output logic                      m_axis_tx_eop,
    output logic                      m_axis_tx_tvalid,
    output logic [3:0]                m_axis_tx_tuser,
    output logic                      cpl_busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_BEAT0 = 3'd3;
    localparam logic [2:0] S_BEAT1 = 3'd4;

    localparam logic [1:0] LAT_LAST = 2'(C_RD_LAT - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  tag_q, tag_d;
    logic [15:0] rid_q, rid_d;
    logic [2:0]  tc_q, tc_d;
    logic [1:0]  attr_q, attr_d;
    logic [7:0]  idx_q, idx_d;
    logic        ur_q, ur_d;
    logic [1:0]  lat_q, lat_d;
    logic [31:0] data_q, data_d;
    logic        tvalid_q, tvalid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic [63:0] tdata_q, tdata_d;
    logic [7:0]  tkeep_q, tkeep_d;

    logic        is_ur;
    logic        unused_ok;
    logic [31:0] dw2;

`ifdef CPL_UR_EN
    assign is_ur     = (req_len != 10'd1);
    assign unused_ok = ^req_addr[1:0];
`else
    assign is_ur     = 1'b0;
    assign unused_ok = ^{req_addr[1:0], req_len};
`endif

    function automatic logic [31:0] hdr_dw0(input logic [2:0] tc,
                                            input logic [1:0] attr,
                                            input logic       ur);
        hdr_dw0 = {ur ? 3'b000 : 3'b010, 5'b01010, 1'b0, tc, 4'b0000,
                   1'b0, 1'b0, attr, 2'b00, ur ? 10'd0 : 10'd1};
    endfunction

    function automatic logic [31:0] hdr_dw1(input logic [15:0] cid,
                                            input logic        ur);
        hdr_dw1 = {cid, ur ? 3'b001 : 3'b000, 1'b0, 12'd4};
    endfunction

    // Lower address bits are rebuilt from the DW index; [1:0] are always zero.
    assign dw2 = {rid_q, tag_q, 1'b0, idx_q[4:0], 2'b00};

    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        rid_d    = rid_q;
        tc_d     = tc_q;
        attr_d   = attr_q;
        idx_d    = idx_q;
        ur_d     = ur_q;
        lat_d    = lat_q;
        data_d   = data_q;
        tvalid_d = tvalid_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tag_d  = req_tag;
                    rid_d  = req_rid;
                    tc_d   = req_tc;
                    attr_d = req_attr;
                    idx_d  = req_addr[9:2];
                    ur_d   = is_ur;
                    if (is_ur) begin
                        state_d  = S_BEAT0;
                        tvalid_d = 1'b1;
                        sop_d    = 1'b1;
                        eop_d    = 1'b0;
                        tkeep_d  = 8'hFF;
                        tdata_d  = {hdr_dw1(cfg_completer_id, 1'b1),
                                    hdr_dw0(req_tc, req_attr, 1'b1)};
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                lat_d   = 2'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    data_d   = rd_data;
                    state_d  = S_BEAT0;
                    tvalid_d = 1'b1;
                    sop_d    = 1'b1;
                    eop_d    = 1'b0;
                    tkeep_d  = 8'hFF;
                    tdata_d  = {hdr_dw1(cfg_completer_id, 1'b0),
                                hdr_dw0(tc_q, attr_q, 1'b0)};
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_BEAT0: begin
                if (m_axis_tx_tready) begin
                    state_d = S_BEAT1;
                    sop_d   = 1'b0;
                    eop_d   = 1'b1;
                    tdata_d = {ur_q ? 32'h0 : data_q, dw2};
                    tkeep_d = ur_q ? 8'h0F : 8'hFF;
                end
            end
            S_BEAT1: begin
                if (m_axis_tx_tready) begin
                    state_d  = S_IDLE;
                    tvalid_d = 1'b0;
                    eop_d    = 1'b0;
                    tdata_d  = 64'h0;
                    tkeep_d  = 8'h00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_nm) begin
            state_q  <= S_IDLE;
            tag_q    <= 8'h0;
            rid_q    <= 16'h0;
            tc_q     <= 3'h0;
            attr_q   <= 2'h0;
            idx_q    <= 8'h0;
            ur_q     <= 1'b0;
            lat_q    <= 2'd0;
            data_q   <= 32'h0;
            tvalid_q <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            tdata_q  <= 64'h0;
            tkeep_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            rid_q    <= rid_d;
            tc_q     <= tc_d;
            attr_q   <= attr_d;
            idx_q    <= idx_d;
            ur_q     <= ur_d;
            lat_q    <= lat_d;
            data_q   <= data_d;
            tvalid_q <= tvalid_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
        end
    end

    assign req_ready        = (state_q == S_IDLE);
    assign cpl_busy         = (state_q != S_IDLE);
    assign rd_en            = (state_q == S_RD);
    assign rd_addr          = idx_q;
    assign m_axis_tx_tvalid = tvalid_q;
    assign m_axis_tx_sop    = sop_q;
    assign m_axis_tx_eop    = eop_q;
    assign m_axis_tx_tdata  = tdata_q;
    assign m_axis_tx_tkeep  = tkeep_q;
    assign m_axis_tx_tuser  = 4'b0000;

endmodule
